// File: rtl/gate3_vector_checker.sv
// Exhaustive 3-input gate checker: walks {A,B,C} through 0..7, samples Y after a
// settle window, and compares against a truth table, reporting count/first-fail/pass.
module gate3_vector_checker #(
  parameter int          SETTLE = 2,
  parameter int          ERR_W  = 4,
  parameter logic [7:0]  EXP_TT = 8'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LAST} state_t;

  state_t           state, state_nxt;
  logic [2:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic             sample;
  logic             mismatch;

  assign sample   = (state == S_SETTLE) && (cnt == CNT_W'(SETTLE - 1));
  // 4-state compare so an X/Z on Y is reported as a failure, not silently matched
  assign mismatch = (Y !== EXP_TT[vec]);
  assign {A, B, C} = vec;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (sample && vec == 3'd7) state_nxt = S_LAST;
      S_LAST:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (sample) begin
            if (mismatch) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= vec;
              end
            end
            // vec parks at 7 after the last sample rather than wrapping
            if (vec != 3'd7) begin
              vec <= vec + 3'd1;
              cnt <= '0;
            end
          end
        end
        S_LAST: begin
          // fail_valid already includes the vector-7 sample taken on the previous edge
          done <= 1'b1;
          busy <= 1'b0;
          pass <= ~fail_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate3_vector_checker.sv
// Bench for gate3_vector_checker: three instances (SETTLE/ERR_W variants) each with a
// modelled gate; table of fault modes plus hand sequences for reset/restart corners.
module tb_gate3_vector_checker;

  localparam int NI = 3;
  localparam int M_GOOD = 0, M_ST1 = 1, M_ST0 = 2, M_INV = 3, M_BAD3 = 4, M_XAT4 = 5;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic       fv;
    logic [2:0] fvec;
    int         lat;
  } exp_t;

  typedef struct {
    int         g;
    int         mode;
    logic       pass;
    logic [3:0] err;
    logic       fv;
    logic [2:0] fvec;
  } vec_t;

  logic                 clk;
  logic [NI-1:0]        rst, start, y, a, b, c, busy, done, pass, fail_valid;
  logic [NI-1:0][2:0]   fail_vec;
  logic [NI-1:0][3:0]   err_cnt;
  int                   mode [NI];
  logic                 xval;
  int                   total, bad;
  exp_t                 q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S  = (g == 1) ? 1 : 2;
    localparam int EW = (g == 2) ? 2 : 4;
    logic [EW-1:0] ec;
    gate3_vector_checker #(.SETTLE(S), .ERR_W(EW), .EXP_TT(8'h7F)) u_dut (
      .clk(clk), .rst(rst[g]), .start(start[g]),
      .A(a[g]), .B(b[g]), .C(c[g]), .Y(y[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err_cnt(ec),
      .fail_valid(fail_valid[g]), .fail_vec(fail_vec[g])
    );
    assign err_cnt[g] = 4'(ec);
  end

  // Gate models driven from the checker's A/B/C
  always_comb begin
    y = '0;
    for (int g = 0; g < NI; g++) begin
      case (mode[g])
        M_GOOD:  y[g] = ~(a[g] & b[g] & c[g]);
        M_ST1:   y[g] = 1'b1;
        M_ST0:   y[g] = 1'b0;
        M_INV:   y[g] = a[g] & b[g] & c[g];
        M_BAD3:  y[g] = ({a[g], b[g], c[g]} == 3'd3) ? 1'b0 : ~(a[g] & b[g] & c[g]);
        M_XAT4:  y[g] = ({a[g], b[g], c[g]} == 3'd4) ? xval : ~(a[g] & b[g] & c[g]);
        default: y[g] = 1'b0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Entered and left at a negedge. extra: cycle index at which to pulse start mid-run.
  task automatic run(input int g, input int md, input logic ep, input logic [3:0] ee,
                     input logic ef, input logic [2:0] efv, input int extra, input bit hold);
    exp_t e;
    int k, s, v;
    s = (g == 1) ? 1 : 2;
    mode[g] = md;
    q.push_back('{ep, ee, ef, efv, 8 * s + 1});
    start[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    chk($sformatf("clr%0d", g), {err_cnt[g], pass[g], fail_valid[g], done[g]}, 32'd0);
    while (!done[g] && k <= 200) begin
      v = (k / s > 7) ? 7 : k / s;
      chk($sformatf("step%0d_k%0d", g, k), {busy[g], a[g], b[g], c[g]}, {28'd0, 1'b1, 3'(v)});
      start[g] = hold ? 1'b1 : (k == extra);
      @(negedge clk);
      k++;
    end
    if (!hold) start[g] = 1'b0;
    e = q.pop_front();
    chk($sformatf("lat%0d", g), k, e.lat);
    chk($sformatf("res%0d", g), {busy[g], pass[g], err_cnt[g], fail_valid[g], fail_vec[g]},
        {23'd0, 1'b0, e.pass, e.err, e.fv, e.fvec});
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("post%0d", g), {done[g], busy[g], a[g], b[g], c[g]}, 32'b00111);
    end
  endtask

  initial begin
    vec_t tbl[10];
    logic xmis;
    bit   seen;
    total = 0; bad = 0;
    xval = 1'bx;
    for (int g = 0; g < NI; g++) mode[g] = M_GOOD;
    start = '0;
    rst = '1;
    #1;
    xmis = (xval !== 1'b1);
    tbl[0] = '{0, M_GOOD, 1'b1, 4'd0, 1'b0, 3'd0};
    tbl[1] = '{0, M_ST1,  1'b0, 4'd1, 1'b1, 3'd7};
    tbl[2] = '{0, M_ST0,  1'b0, 4'd7, 1'b1, 3'd0};
    tbl[3] = '{0, M_INV,  1'b0, 4'd8, 1'b1, 3'd0};
    tbl[4] = '{0, M_BAD3, 1'b0, 4'd1, 1'b1, 3'd3};
    tbl[5] = '{2, M_ST0,  1'b0, 4'd3, 1'b1, 3'd0};
    tbl[6] = '{2, M_INV,  1'b0, 4'd3, 1'b1, 3'd0};
    tbl[7] = '{1, M_XAT4, ~xmis, xmis ? 4'd1 : 4'd0, xmis, xmis ? 3'd4 : 3'd0};
    tbl[8] = '{1, M_GOOD, 1'b1, 4'd0, 1'b0, 3'd0};
    tbl[9] = '{0, M_XAT4, ~xmis, xmis ? 4'd1 : 4'd0, xmis, xmis ? 3'd4 : 3'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++)
      chk($sformatf("reset%0d", g),
          {a[g], b[g], c[g], busy[g], done[g], pass[g], err_cnt[g], fail_valid[g], fail_vec[g]}, 32'd0);
    rst = '0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run(tbl[i].g, tbl[i].mode, tbl[i].pass, tbl[i].err, tbl[i].fv, tbl[i].fvec, -1, 1'b0);

    // start pulses during the run and during LAST are ignored
    run(0, M_GOOD, 1'b1, 4'd0, 1'b0, 3'd0, 6, 1'b0);
    run(0, M_ST1, 1'b0, 4'd1, 1'b1, 3'd7, 16, 1'b0);

    // rst on the 5th clock of a run: immediate abort, no done afterwards
    mode[0] = M_ST0;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst",
        {a[0], b[0], c[0], busy[0], done[0], pass[0], err_cnt[0], fail_valid[0], fail_vec[0]}, 32'd0);
    rst[0] = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen = 1'b1;
    end
    chk("no_done_after_rst", {31'd0, seen}, 32'd0);
    run(0, M_GOOD, 1'b1, 4'd0, 1'b0, 3'd0, -1, 1'b0);

    // start held high: back-to-back runs, second begins on the edge after done
    run(0, M_ST1, 1'b0, 4'd1, 1'b1, 3'd7, -1, 1'b1);
    run(0, M_ST1, 1'b0, 4'd1, 1'b1, 3'd7, -1, 1'b1);
    start[0] = 1'b0;
    @(negedge clk);
    chk("held_stop", {done[0], busy[0], pass[0], err_cnt[0]}, {1'b0, 1'b0, 1'b0, 4'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
